async_fifo_rd_stream: RTL and testbench

- Read-side adapter placed directly downstream of async_fifo, in the rd_clk domain.
- Converts the FIFO's rd_en/rd_data/empty interface, where data returns a fixed latency after rd_en, into a valid/ready stream.
- Uses a small credit-managed output buffer, so the stream runs at full throughput and holds data stable under backpressure.
- Supports a synchronous flush that discards buffered and in-flight words.

---
 rtl/async_fifo_rd_stream_if.sv | 11 +
 rtl/async_fifo_rd_stream.sv | 97 +++++++++
 tb/tb_async_fifo_rd_stream.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/async_fifo_rd_stream_if.sv
// Valid/ready stream carrying words read out of async_fifo.
interface async_fifo_rd_stream_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/async_fifo_rd_stream.sv
// Read-side adapter for async_fifo: turns fixed-latency rd_en/rd_data into a
// valid/ready stream through a credit-managed output buffer.
module async_fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned BUF_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]       fifo_rd_data,
    input  logic                        fifo_empty,
    async_fifo_rd_stream_if.master      m,
    input  logic                        flush,
    output logic [$clog2(BUF_DEPTH):0]  level,
    output logic                        overflow_err
);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned SUM_W = LVL_W + 1;

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [RD_LATENCY-1:0] pend;
    logic                  m_valid_q;

    logic [LVL_W-1:0]      inflight_c;
    logic [LVL_W-1:0]      level_nxt_c;
    logic                  arrive_c;
    logic                  pop_c;
    logic                  full_c;
    logic                  wr_c;

    // Reads issued but not yet returned; counted as consumed buffer credit
    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight_c = inflight_c + LVL_W'(pend[i]);
        end
    end

    always_comb begin
        arrive_c    = pend[RD_LATENCY-1];
        pop_c       = m_valid_q & m.m_ready;
        full_c      = (level == LVL_W'(BUF_DEPTH));
        wr_c        = arrive_c & ~(full_c & ~pop_c) & ~flush;
        level_nxt_c = level + LVL_W'(wr_c) - LVL_W'(pop_c);
        fifo_rd_en  = rst_n & ~flush & ~fifo_empty &
                      ((SUM_W'(level) + SUM_W'(inflight_c)) < SUM_W'(BUF_DEPTH));
    end

    assign m.m_valid = m_valid_q;
    assign m.m_data  = mem[head];

    // Pointers, level and in-flight shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            level        <= '0;
            pend         <= '0;
            m_valid_q    <= 1'b0;
            overflow_err <= 1'b0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            level     <= '0;
            pend      <= '0;
            m_valid_q <= 1'b0;
        end else begin
            pend      <= RD_LATENCY'({pend, fifo_rd_en});
            level     <= level_nxt_c;
            m_valid_q <= (level_nxt_c != '0);
            if (wr_c) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop_c) begin
                head <= head + PTR_W'(1);
            end
            if (arrive_c && full_c && !pop_c) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Buffer storage; cleared on reset so m_data starts at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_c) begin
            mem[tail] <= fifo_rd_data;
        end
    end
endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Bench for async_fifo_rd_stream: lane 0 uses RD_LATENCY=1, lane 1 RD_LATENCY=2,
// both fed from their own FIFO model and checked against a scoreboard queue.
module tb_async_fifo_rd_stream;
    localparam int unsigned DW = 8;
    localparam int unsigned BD = 4;
    localparam int unsigned LW = $clog2(BD) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m_ready = 1'b0;
    logic flush = 1'b0;
    logic empty_force = 1'b0;

    always #5 clk = ~clk;

    logic [1:0]    rd_en_v;
    logic [1:0]    fifo_empty_v;
    logic [1:0]    m_valid_v;
    logic [1:0]    ovf_v;
    logic [DW-1:0] rd_data_a [2];
    logic [DW-1:0] m_data_a  [2];
    logic [LW-1:0] level_a   [2];

    logic [DW-1:0] fifo_q [2][$];
    logic [DW-1:0] sb     [2][$];
    int            bad_rd [2];

    int            checks = 0;
    int            errors = 0;
    int            rx_cnt [2];
    logic [1:0]    hold;
    logic [DW-1:0] hold_data [2];

    for (genvar g = 0; g < 2; g++) begin : gen_lane
        async_fifo_rd_stream_if #(.DATA_WIDTH(DW)) sif ();
        logic [DW-1:0] st1;
        logic [DW-1:0] st2;
        logic [DW-1:0] w;
        logic          fe;

        assign sif.m_ready     = m_ready;
        assign m_valid_v[g]    = sif.m_valid;
        assign m_data_a[g]     = sif.m_data;
        assign rd_data_a[g]    = (g == 0) ? st1 : st2;
        assign fifo_empty_v[g] = fe;

        async_fifo_rd_stream #(
            .DATA_WIDTH(DW), .RD_LATENCY(g + 1), .BUF_DEPTH(BD)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .fifo_rd_en   (rd_en_v[g]),
            .fifo_rd_data (rd_data_a[g]),
            .fifo_empty   (fifo_empty_v[g]),
            .m            (sif),
            .flush        (flush),
            .level        (level_a[g]),
            .overflow_err (ovf_v[g])
        );

        // FIFO model: rd_data appears RD_LATENCY cycles after rd_en
        always @(posedge clk) begin
            if (!rst_n) begin
                sb[g].delete();
            end else begin
                if (flush) sb[g].delete();
                if (rd_en_v[g]) begin
                    if (fifo_q[g].size() != 0) begin
                        w = fifo_q[g].pop_front();
                        st1 <= w;
                        sb[g].push_back(w);
                    end else begin
                        bad_rd[g] = bad_rd[g] + 1;
                    end
                end
            end
            st2 <= st1;
            fe  <= empty_force || (fifo_q[g].size() == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [DW-1:0] exp;
        for (int l = 0; l < 2; l++) begin
            check("overflow_err", 32'(ovf_v[l]), 32'(0));
            check("level_bound", 32'(level_a[l] <= LW'(BD)), 32'(1));
            if (hold[l]) begin
                check("hold_valid", 32'(m_valid_v[l]), 32'(1));
                check("hold_data", 32'(m_data_a[l]), 32'(hold_data[l]));
            end
            if (m_valid_v[l] && m_ready) begin
                exp = 'x;
                if (sb[l].size() != 0) exp = sb[l].pop_front();
                check("stream_data", 32'(m_data_a[l]), 32'(exp));
                rx_cnt[l]++;
            end
            hold[l]      = m_valid_v[l] && !m_ready && !flush;
            hold_data[l] = m_data_a[l];
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input int base, input int mul);
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < n; i++) fifo_q[l].push_back(DW'(base + i * mul));
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        m_ready = 1'b1;
        empty_force = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            sample();
            done = (fifo_q[0].size() == 0) && (fifo_q[1].size() == 0) &&
                   (sb[0].size() == 0) && (sb[1].size() == 0) && (m_valid_v == 2'b00);
            advance();
        end
        check("drain_done", 32'(done), 32'(1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] nxt;
        logic          found;
        int            rx0 [2];
        hold = '0;
        rx_cnt[0] = 0; rx_cnt[1] = 0;
        bad_rd[0] = 0; bad_rd[1] = 0;

        // Reset with a non-empty FIFO
        load(100, 0, 1);
        m_ready = 1'b1;
        repeat (3) begin sample(); advance(); end
        sample();
        for (int l = 0; l < 2; l++) begin
            check("rst_rd_en", 32'(rd_en_v[l]), 32'(0));
            check("rst_m_valid", 32'(m_valid_v[l]), 32'(0));
            check("rst_level", 32'(level_a[l]), 32'(0));
            check("rst_m_data", 32'(m_data_a[l]), 32'(0));
        end
        advance();
        rst_n = 1'b1;

        // Streaming: first word two cycles after first issue (lane 0)
        sample();
        for (int l = 0; l < 2; l++) begin
            check("rel_rd_en", 32'(rd_en_v[l]), 32'(1));
            check("lat_valid0", 32'(m_valid_v[l]), 32'(0));
        end
        advance();
        sample();
        check("lat_valid1", 32'(m_valid_v), 32'(2'b00));
        advance();
        sample();
        check("lat_valid2", 32'(m_valid_v), 32'(2'b01));
        check("first_word", 32'(m_data_a[0]), 32'(0));
        advance();
        for (int c = 0; c < 40; c++) begin
            sample();
            for (int l = 0; l < 2; l++) begin
                check("no_gap_valid", 32'(m_valid_v[l]), 32'(1));
                check("arrive_pop_level", 32'(level_a[l]), 32'(1));
            end
            advance();
        end

        // Backpressure mid-stream
        m_ready = 1'b0;
        repeat (19) begin sample(); advance(); end
        sample();
        for (int l = 0; l < 2; l++) begin
            check("bp_level", 32'(level_a[l]), 32'(BD));
            check("bp_rd_en", 32'(rd_en_v[l]), 32'(0));
        end
        advance();
        drain();
        check("rx_after_stream0", 32'(rx_cnt[0]), 32'(100));
        check("rx_after_stream1", 32'(rx_cnt[1]), 32'(100));

        // Flush at level 3 with one read in flight (lane 0)
        m_ready = 1'b0;
        load(10, 100, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            sample();
            if (level_a[0] == LW'(3)) found = 1'b1;
            else advance();
        end
        check("flush_setup", 32'(found), 32'(1));
        flush = 1'b1;
        hold  = '0;
        nxt   = fifo_q[0][0];
        advance();
        flush = 1'b0;
        sample();
        for (int l = 0; l < 2; l++) begin
            check("flush_valid", 32'(m_valid_v[l]), 32'(0));
            check("flush_level", 32'(level_a[l]), 32'(0));
        end
        advance();
        m_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            sample();
            if (m_valid_v[0]) begin
                found = 1'b1;
                check("flush_next_word", 32'(m_data_a[0]), 32'(nxt));
            end
            advance();
        end
        check("flush_resume", 32'(found), 32'(1));
        drain();

        // Flush coincident with a pop, mid-stream
        load(30, 200, 1);
        repeat (10) begin sample(); advance(); end
        flush = 1'b1;
        rx0[0] = rx_cnt[0];
        sample();
        check("fp_valid_at_flush", 32'(m_valid_v[0]), 32'(1));
        check("fp_popped", 32'(rx_cnt[0] - rx0[0]), 32'(1));
        for (int l = 0; l < 2; l++) check("fp_rd_en_off", 32'(rd_en_v[l]), 32'(0));
        advance();
        flush = 1'b0;
        sample();
        for (int l = 0; l < 2; l++) begin
            check("fp_valid_after", 32'(m_valid_v[l]), 32'(0));
            check("fp_level_after", 32'(level_a[l]), 32'(0));
            check("fp_rd_en_resume", 32'(rd_en_v[l]), 32'(1));
        end
        advance();
        drain();

        // Random ready and empty
        rx0[0] = rx_cnt[0];
        rx0[1] = rx_cnt[1];
        load(1000, 3, 7);
        for (int i = 0; i < 20000; i++) begin
            if ((rx_cnt[0] - rx0[0] >= 1000) && (rx_cnt[1] - rx0[1] >= 1000)) break;
            m_ready     = 1'($urandom_range(0, 1));
            empty_force = ($urandom_range(0, 3) == 0);
            sample();
            advance();
        end
        drain();
        check("rand_rx0", 32'(rx_cnt[0] - rx0[0]), 32'(1000));
        check("rand_rx1", 32'(rx_cnt[1] - rx0[1]), 32'(1000));
        check("bad_rd0", 32'(bad_rd[0]), 32'(0));
        check("bad_rd1", 32'(bad_rd[1]), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
